// File: rtl/calc2_pkg.sv
// calc2_pkg: shared definitions for the calc2 arbiter slice.
//   - command encodings (NOP/ADD/SUB/SHL/SHR) and their unit class
//   - port count, tag width and the derived scoreboard geometry
//   - classify(): maps a raw command onto the unit that executes it
package calc2_pkg;

    localparam int NUM_PORTS = 4;
    localparam int TAG_W     = 2;
    localparam int CMD_W     = 4;
    localparam int PORT_W    = 2;
    // One scoreboard bit per {port, tag}
    localparam int SB_W      = NUM_PORTS * (1 << TAG_W);
    localparam int SB_IDX_W  = PORT_W + TAG_W;

    typedef enum logic [CMD_W-1:0] {
        CMD_NOP = 4'd0,
        CMD_ADD = 4'd1,
        CMD_SUB = 4'd2,
        CMD_SHL = 4'd5,
        CMD_SHR = 4'd6
    } cmd_e;

    typedef enum logic [1:0] {
        CLS_IDLE,
        CLS_ADDER,
        CLS_SHIFT,
        CLS_INVALID
    } unit_cls_e;

    function automatic unit_cls_e classify(input logic [CMD_W-1:0] cmd);
        unit_cls_e cls;
        case (cmd)
            CMD_NOP:          cls = CLS_IDLE;
            CMD_ADD, CMD_SUB: cls = CLS_ADDER;
            CMD_SHL, CMD_SHR: cls = CLS_SHIFT;
            default:          cls = CLS_INVALID;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/calc2_arbiter_if.sv
// calc2_arbiter_if: bundle of all request, dispatch, completion and status
// signals of the calc2 arbiter.
//   slave  modport: the arbiter (consumes requests/completions, drives acks,
//                   dispatches, invalid-op pulses and sb_err)
//   master modport: the environment (requesters and execution units)
interface calc2_arbiter_if;
    import calc2_pkg::*;

    // Requester ports
    logic [CMD_W-1:0]    req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in;
    logic [TAG_W-1:0]    req1_tag_in, req2_tag_in, req3_tag_in, req4_tag_in;
    logic                req1_ack, req2_ack, req3_ack, req4_ack;

    // Unit dispatch
    logic                prio_adder_vld, prio_shift_vld;
    logic [CMD_W-1:0]    prio_adder_cmd, prio_shift_cmd;
    logic [SB_IDX_W-1:0] prio_adder_tag, prio_shift_tag;

    // Unit completion
    logic                adder_done, shift_done;
    logic [SB_IDX_W-1:0] adder_done_tag, shift_done_tag;

    // Status
    logic                port1_invalid_op, port2_invalid_op, port3_invalid_op, port4_invalid_op;
    logic [TAG_W-1:0]    port1_invalid_tag, port2_invalid_tag, port3_invalid_tag, port4_invalid_tag;
    logic                sb_err;

    modport slave (
        input  req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
        input  req1_tag_in, req2_tag_in, req3_tag_in, req4_tag_in,
        output req1_ack, req2_ack, req3_ack, req4_ack,
        output prio_adder_vld, prio_adder_cmd, prio_adder_tag,
        output prio_shift_vld, prio_shift_cmd, prio_shift_tag,
        input  adder_done, shift_done, adder_done_tag, shift_done_tag,
        output port1_invalid_op, port2_invalid_op, port3_invalid_op, port4_invalid_op,
        output port1_invalid_tag, port2_invalid_tag, port3_invalid_tag, port4_invalid_tag,
        output sb_err
    );

    modport master (
        output req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
        output req1_tag_in, req2_tag_in, req3_tag_in, req4_tag_in,
        input  req1_ack, req2_ack, req3_ack, req4_ack,
        input  prio_adder_vld, prio_adder_cmd, prio_adder_tag,
        input  prio_shift_vld, prio_shift_cmd, prio_shift_tag,
        output adder_done, shift_done, adder_done_tag, shift_done_tag,
        input  port1_invalid_op, port2_invalid_op, port3_invalid_op, port4_invalid_op,
        input  port1_invalid_tag, port2_invalid_tag, port3_invalid_tag, port4_invalid_tag,
        input  sb_err
    );

endinterface

// File: rtl/calc2_rr_pick.sv
// calc2_rr_pick: combinational round-robin picker.
//   req      : one request bit per port (bit 0 = port 1)
//   ptr      : port index where the search starts
//   grant    : one-hot grant (all zero when nothing requests)
//   any      : a grant was issued
//   ptr_next : granted port + 1 (wrapping), or ptr when nothing was granted
module calc2_rr_pick
    import calc2_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_W-1:0]    ptr,
    output logic [NUM_PORTS-1:0] grant,
    output logic                 any,
    output logic [PORT_W-1:0]    ptr_next
);

    logic [PORT_W-1:0] idx;

    always_comb begin
        grant    = '0;
        any      = 1'b0;
        ptr_next = ptr;
        idx      = '0;
        // Ascending search from ptr; the 2-bit index wraps port 4 back to port 1
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = ptr + PORT_W'(i);
            if (!any && req[idx]) begin
                grant[idx] = 1'b1;
                any        = 1'b1;
                ptr_next   = idx + PORT_W'(1);
            end
        end
    end

endmodule

// File: rtl/calc2_arbiter.sv
// calc2_arbiter: four-port command arbiter for an adder and a shifter unit.
//   c_clk  : clock, all state on the rising edge
//   reset  : synchronous active-high reset
//   bus    : calc2_arbiter_if.slave -- requests/acks, registered unit
//            dispatch (vld/cmd/{port,tag}), unit completions, registered
//            invalid-command pulses and the sticky scoreboard error.
// Each {port,tag} may have only one operation in flight; a 16-bit
// scoreboard tracks them. Each unit has its own round-robin pointer.
module calc2_arbiter
    import calc2_pkg::*;
(
    input  logic            c_clk,
    input  logic            reset,
    calc2_arbiter_if.slave  bus
);

    logic [CMD_W-1:0]      cmd_in [NUM_PORTS];
    logic [TAG_W-1:0]      tag_in [NUM_PORTS];
    unit_cls_e             cls    [NUM_PORTS];
    logic [NUM_PORTS-1:0]  add_req, shf_req, inv_req, ack;
    logic [NUM_PORTS-1:0]  add_gnt, shf_gnt;
    logic                  add_any, shf_any;
    logic [PORT_W-1:0]     add_ptr, shf_ptr, add_ptr_next, shf_ptr_next;

    logic [SB_W-1:0]       sb_q, sb_d;
    logic                  sb_err_q, err_d;

    logic [CMD_W-1:0]      add_cmd_d, shf_cmd_d;
    logic [SB_IDX_W-1:0]   add_tag_d, shf_tag_d;

    logic                  add_vld_p1, shf_vld_p1;
    logic [CMD_W-1:0]      add_cmd_p1, shf_cmd_p1;
    logic [SB_IDX_W-1:0]   add_tag_p1, shf_tag_p1;
    logic [NUM_PORTS-1:0]  inv_vld_p1;
    logic [TAG_W-1:0]      inv_tag_p1 [NUM_PORTS];

    function automatic logic [SB_IDX_W-1:0] sb_idx(input int port, input logic [TAG_W-1:0] tag);
        return {PORT_W'(port), tag};
    endfunction

    assign cmd_in[0] = bus.req1_cmd_in;
    assign cmd_in[1] = bus.req2_cmd_in;
    assign cmd_in[2] = bus.req3_cmd_in;
    assign cmd_in[3] = bus.req4_cmd_in;
    assign tag_in[0] = bus.req1_tag_in;
    assign tag_in[1] = bus.req2_tag_in;
    assign tag_in[2] = bus.req3_tag_in;
    assign tag_in[3] = bus.req4_tag_in;

    // Request qualification: class decode, registered scoreboard check,
    // everything suppressed while reset is high
    always_comb begin
        add_req = '0;
        shf_req = '0;
        inv_req = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            cls[p]     = classify(cmd_in[p]);
            add_req[p] = !reset && (cls[p] == CLS_ADDER)   && !sb_q[sb_idx(p, tag_in[p])];
            shf_req[p] = !reset && (cls[p] == CLS_SHIFT)   && !sb_q[sb_idx(p, tag_in[p])];
            inv_req[p] = !reset && (cls[p] == CLS_INVALID);
        end
    end

    calc2_rr_pick u_add_pick (
        .req      (add_req),
        .ptr      (add_ptr),
        .grant    (add_gnt),
        .any      (add_any),
        .ptr_next (add_ptr_next)
    );

    calc2_rr_pick u_shf_pick (
        .req      (shf_req),
        .ptr      (shf_ptr),
        .grant    (shf_gnt),
        .any      (shf_any),
        .ptr_next (shf_ptr_next)
    );

    // Invalid commands are consumed unconditionally, in parallel with grants
    assign ack = add_gnt | shf_gnt | inv_req;
    assign bus.req1_ack = ack[0];
    assign bus.req2_ack = ack[1];
    assign bus.req3_ack = ack[2];
    assign bus.req4_ack = ack[3];

    // Dispatch mux: zeros when the unit has no grant
    always_comb begin
        add_cmd_d = '0;
        add_tag_d = '0;
        shf_cmd_d = '0;
        shf_tag_d = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (add_gnt[p]) begin
                add_cmd_d = cmd_in[p];
                add_tag_d = sb_idx(p, tag_in[p]);
            end
            if (shf_gnt[p]) begin
                shf_cmd_d = cmd_in[p];
                shf_tag_d = sb_idx(p, tag_in[p]);
            end
        end
    end

    // Scoreboard update. A grant only targets a clear bit and a valid
    // completion only targets a set bit, so set and clear never collide.
    // Duplicate completions of the same {port,tag} clear once and flag.
    always_comb begin
        sb_d  = sb_q;
        err_d = 1'b0;
        if (bus.adder_done) begin
            if (sb_q[bus.adder_done_tag]) sb_d[bus.adder_done_tag] = 1'b0;
            else                          err_d = 1'b1;
        end
        if (bus.shift_done) begin
            if (bus.adder_done && (bus.adder_done_tag == bus.shift_done_tag)) err_d = 1'b1;
            else if (sb_q[bus.shift_done_tag]) sb_d[bus.shift_done_tag] = 1'b0;
            else                               err_d = 1'b1;
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (add_gnt[p] || shf_gnt[p]) sb_d[sb_idx(p, tag_in[p])] = 1'b1;
        end
    end

    // ---- stage p1: registered dispatch, invalid pulses, scoreboard ----
    always_ff @(posedge c_clk) begin
        if (reset) begin
            sb_q       <= '0;
            sb_err_q   <= 1'b0;
            add_ptr    <= '0;
            shf_ptr    <= '0;
            add_vld_p1 <= 1'b0;
            add_cmd_p1 <= '0;
            add_tag_p1 <= '0;
            shf_vld_p1 <= 1'b0;
            shf_cmd_p1 <= '0;
            shf_tag_p1 <= '0;
            inv_vld_p1 <= '0;
            for (int p = 0; p < NUM_PORTS; p++) inv_tag_p1[p] <= '0;
        end else begin
            sb_q       <= sb_d;
            sb_err_q   <= sb_err_q | err_d;
            add_ptr    <= add_ptr_next;
            shf_ptr    <= shf_ptr_next;
            add_vld_p1 <= add_any;
            add_cmd_p1 <= add_cmd_d;
            add_tag_p1 <= add_tag_d;
            shf_vld_p1 <= shf_any;
            shf_cmd_p1 <= shf_cmd_d;
            shf_tag_p1 <= shf_tag_d;
            inv_vld_p1 <= inv_req;
            for (int p = 0; p < NUM_PORTS; p++)
                inv_tag_p1[p] <= inv_req[p] ? tag_in[p] : '0;
        end
    end

    assign bus.prio_adder_vld    = add_vld_p1;
    assign bus.prio_adder_cmd    = add_cmd_p1;
    assign bus.prio_adder_tag    = add_tag_p1;
    assign bus.prio_shift_vld    = shf_vld_p1;
    assign bus.prio_shift_cmd    = shf_cmd_p1;
    assign bus.prio_shift_tag    = shf_tag_p1;
    assign bus.port1_invalid_op  = inv_vld_p1[0];
    assign bus.port2_invalid_op  = inv_vld_p1[1];
    assign bus.port3_invalid_op  = inv_vld_p1[2];
    assign bus.port4_invalid_op  = inv_vld_p1[3];
    assign bus.port1_invalid_tag = inv_tag_p1[0];
    assign bus.port2_invalid_tag = inv_tag_p1[1];
    assign bus.port3_invalid_tag = inv_tag_p1[2];
    assign bus.port4_invalid_tag = inv_tag_p1[3];
    assign bus.sb_err            = sb_err_q;

endmodule

// File: tb/tb_calc2_arbiter.sv
// tb_calc2_arbiter: directed self-checking bench for calc2_arbiter.
// Each step drives inputs on the falling edge, checks the combinational
// acks, queues the dispatch/invalid outputs expected one cycle later and
// compares them after the next rising edge.
module tb_calc2_arbiter;
    import calc2_pkg::*;

    logic c_clk = 1'b0;
    logic reset;
    always #5 c_clk = ~c_clk;

    calc2_arbiter_if bus_if();

    calc2_arbiter dut (
        .c_clk (c_clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int checks = 0;
    int errors = 0;

    // Expected dispatch {vld, cmd, tag}; expected invalid {op4..op1, tag4..tag1}
    logic [8:0]  add_q [$];
    logic [8:0]  shf_q [$];
    logic [11:0] inv_q [$];

    localparam logic [8:0] NONE = 9'h000;

    function automatic logic [8:0] disp(input logic [3:0] cmd, input logic [3:0] tag);
        return {1'b1, cmd, tag};
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic set_req(input int p, input logic [3:0] cmd, input logic [1:0] tag);
        case (p)
            1: begin bus_if.req1_cmd_in = cmd; bus_if.req1_tag_in = tag; end
            2: begin bus_if.req2_cmd_in = cmd; bus_if.req2_tag_in = tag; end
            3: begin bus_if.req3_cmd_in = cmd; bus_if.req3_tag_in = tag; end
            default: begin bus_if.req4_cmd_in = cmd; bus_if.req4_tag_in = tag; end
        endcase
    endtask

    task automatic done_add(input logic [3:0] tag);
        bus_if.adder_done = 1'b1; bus_if.adder_done_tag = tag;
    endtask

    task automatic done_shf(input logic [3:0] tag);
        bus_if.shift_done = 1'b1; bus_if.shift_done_tag = tag;
    endtask

    // One clock step; inputs already driven at the falling edge
    task automatic cyc(input logic [3:0] eack, input logic [8:0] eadd,
                       input logic [8:0] eshf, input logic [11:0] einv);
        logic [8:0]  ea, es;
        logic [11:0] ei;
        #1;
        chk("ack", {28'd0, bus_if.req4_ack, bus_if.req3_ack, bus_if.req2_ack, bus_if.req1_ack}, {28'd0, eack});
        add_q.push_back(eadd);
        shf_q.push_back(eshf);
        inv_q.push_back(einv);
        @(posedge c_clk);
        @(negedge c_clk);
        bus_if.adder_done = 1'b0;
        bus_if.shift_done = 1'b0;
        ea = add_q.pop_front();
        es = shf_q.pop_front();
        ei = inv_q.pop_front();
        chk("adder_dispatch", {23'd0, bus_if.prio_adder_vld, bus_if.prio_adder_cmd, bus_if.prio_adder_tag}, {23'd0, ea});
        chk("shift_dispatch", {23'd0, bus_if.prio_shift_vld, bus_if.prio_shift_cmd, bus_if.prio_shift_tag}, {23'd0, es});
        chk("invalid", {20'd0, bus_if.port4_invalid_op, bus_if.port3_invalid_op, bus_if.port2_invalid_op,
                        bus_if.port1_invalid_op, bus_if.port4_invalid_tag, bus_if.port3_invalid_tag,
                        bus_if.port2_invalid_tag, bus_if.port1_invalid_tag}, {20'd0, ei});
    endtask

    initial begin
        for (int p = 1; p <= 4; p++) set_req(p, 4'h0, 2'd0);
        bus_if.adder_done = 1'b0; bus_if.adder_done_tag = '0;
        bus_if.shift_done = 1'b0; bus_if.shift_done_tag = '0;
        reset = 1'b1;
        @(negedge c_clk);

        // Reset: requests and completions ignored, outputs zero
        set_req(1, CMD_ADD, 2'd0);
        done_add(4'h3);
        cyc(4'b0000, NONE, NONE, 12'h0);
        chk("sb_err_reset", {31'd0, bus_if.sb_err}, 32'd0);
        reset = 1'b0;
        set_req(1, CMD_NOP, 2'd0);
        cyc(4'b0000, NONE, NONE, 12'h0);
        chk("sb_err_idle", {31'd0, bus_if.sb_err}, 32'd0);

        // Adder round-robin 1,2,3,4,1 with completions every cycle
        set_req(1, CMD_ADD, 2'd0); set_req(2, CMD_ADD, 2'd1);
        set_req(3, CMD_ADD, 2'd2); set_req(4, CMD_ADD, 2'd3);
        cyc(4'b0001, disp(CMD_ADD, 4'h0), NONE, 12'h0);
        set_req(1, CMD_SUB, 2'd1); done_add(4'h0);
        cyc(4'b0010, disp(CMD_ADD, 4'h5), NONE, 12'h0);
        set_req(2, CMD_NOP, 2'd0); done_add(4'h5);
        cyc(4'b0100, disp(CMD_ADD, 4'hA), NONE, 12'h0);
        set_req(3, CMD_NOP, 2'd0); done_add(4'hA);
        cyc(4'b1000, disp(CMD_ADD, 4'hF), NONE, 12'h0);
        set_req(4, CMD_NOP, 2'd0); done_add(4'hF);
        cyc(4'b0001, disp(CMD_SUB, 4'h1), NONE, 12'h0);
        set_req(1, CMD_NOP, 2'd0); done_add(4'h1);
        cyc(4'b0000, NONE, NONE, 12'h0);
        chk("sb_err_rr", {31'd0, bus_if.sb_err}, 32'd0);

        // Adder and shifter grants in the same cycle
        set_req(1, CMD_ADD, 2'd0); set_req(2, CMD_SHL, 2'd1);
        cyc(4'b0011, disp(CMD_ADD, 4'h0), disp(CMD_SHL, 4'h5), 12'h0);
        set_req(1, CMD_NOP, 2'd0); set_req(2, CMD_NOP, 2'd0);
        done_add(4'h0); done_shf(4'h5);
        cyc(4'b0000, NONE, NONE, 12'h0);

        // Shifter pointer now at port 3: port 3 beats port 1, then port 1
        set_req(1, CMD_SHR, 2'd2); set_req(3, CMD_SHR, 2'd0);
        cyc(4'b0100, NONE, disp(CMD_SHR, 4'h8), 12'h0);
        set_req(3, CMD_NOP, 2'd0);
        cyc(4'b0001, NONE, disp(CMD_SHR, 4'h2), 12'h0);
        set_req(1, CMD_NOP, 2'd0); done_shf(4'h8);
        cyc(4'b0000, NONE, NONE, 12'h0);
        done_shf(4'h2);
        cyc(4'b0000, NONE, NONE, 12'h0);
        chk("sb_err_shift", {31'd0, bus_if.sb_err}, 32'd0);

        // Same {port,tag} stalls until the cycle after its completion
        set_req(3, CMD_ADD, 2'd2);
        cyc(4'b0100, disp(CMD_ADD, 4'hA), NONE, 12'h0);
        cyc(4'b0000, NONE, NONE, 12'h0);
        done_add(4'hA);
        cyc(4'b0000, NONE, NONE, 12'h0);
        cyc(4'b0100, disp(CMD_ADD, 4'hA), NONE, 12'h0);
        set_req(3, CMD_NOP, 2'd0); done_add(4'hA);
        cyc(4'b0000, NONE, NONE, 12'h0);

        // Invalid commands on ports 1 and 4: one-cycle pulses, no dispatch
        set_req(1, 4'h3, 2'd1); set_req(4, 4'hF, 2'd3);
        cyc(4'b1001, NONE, NONE, {4'b1001, 2'd3, 2'd0, 2'd0, 2'd1});
        set_req(1, CMD_NOP, 2'd0); set_req(4, CMD_ADD, 2'd3);
        cyc(4'b1000, disp(CMD_ADD, 4'hF), NONE, 12'h0);
        set_req(4, CMD_NOP, 2'd0); done_add(4'hF);
        cyc(4'b0000, NONE, NONE, 12'h0);
        chk("sb_err_inv", {31'd0, bus_if.sb_err}, 32'd0);

        // Stray completion sets a sticky error
        done_shf(4'h7);
        cyc(4'b0000, NONE, NONE, 12'h0);
        chk("sb_err_set", {31'd0, bus_if.sb_err}, 32'd1);
        cyc(4'b0000, NONE, NONE, 12'h0);
        cyc(4'b0000, NONE, NONE, 12'h0);
        chk("sb_err_hold", {31'd0, bus_if.sb_err}, 32'd1);

        // Reset with three tags outstanding
        set_req(1, CMD_ADD, 2'd0); set_req(2, CMD_SHL, 2'd1);
        cyc(4'b0011, disp(CMD_ADD, 4'h0), disp(CMD_SHL, 4'h5), 12'h0);
        set_req(1, CMD_NOP, 2'd0); set_req(2, CMD_NOP, 2'd0); set_req(3, CMD_ADD, 2'd2);
        cyc(4'b0100, disp(CMD_ADD, 4'hA), NONE, 12'h0);
        reset = 1'b1;
        set_req(1, CMD_ADD, 2'd0);
        cyc(4'b0000, NONE, NONE, 12'h0);
        chk("sb_err_rst2", {31'd0, bus_if.sb_err}, 32'd0);
        reset = 1'b0;
        set_req(2, CMD_SHL, 2'd1);
        cyc(4'b0011, disp(CMD_ADD, 4'h0), disp(CMD_SHL, 4'h5), 12'h0);
        set_req(1, CMD_NOP, 2'd0); set_req(2, CMD_NOP, 2'd0);
        cyc(4'b0100, disp(CMD_ADD, 4'hA), NONE, 12'h0);

        // Both units complete the same tag: cleared once, error flagged
        set_req(3, CMD_NOP, 2'd0); done_add(4'h0); done_shf(4'h0);
        cyc(4'b0000, NONE, NONE, 12'h0);
        chk("sb_err_dup", {31'd0, bus_if.sb_err}, 32'd1);
        set_req(1, CMD_ADD, 2'd0);
        cyc(4'b0001, disp(CMD_ADD, 4'h0), NONE, 12'h0);

        // Completion of a tag discarded by reset hits a clear bit
        set_req(1, CMD_NOP, 2'd0);
        reset = 1'b1;
        cyc(4'b0000, NONE, NONE, 12'h0);
        chk("sb_err_rst3", {31'd0, bus_if.sb_err}, 32'd0);
        reset = 1'b0;
        done_shf(4'h5);
        cyc(4'b0000, NONE, NONE, 12'h0);
        chk("sb_err_stale", {31'd0, bus_if.sb_err}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc2_arbiter.md
CALC2_ARBITER -- requirements
Module: calc2_arbiter

Interface
REQ-001 c_clk  in  1  sole clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 reqN_cmd_in (N=1..4)  in  [0:3]  port N command; 0 = idle.
REQ-004 reqN_tag_in (N=1..4)  in  [0:1]  port N tag; held with cmd until ack.
REQ-005 reqN_ack (N=1..4)  out  1  combinational; request consumed this cycle; requester presents next cmd (or 0) next cycle.
REQ-006 prio_adder_vld  out  1  registered; adder dispatch valid.
REQ-007 prio_adder_cmd  out  [0:3]  registered adder command.
REQ-008 prio_adder_tag  out  [0:3]  registered {port-1[0:1], tag[0:1]}.
REQ-009 prio_shift_vld / prio_shift_cmd / prio_shift_tag  out  1 / [0:3] / [0:3]  shifter equivalents.
REQ-010 adder_done, shift_done  in  1  unit completion pulse.
REQ-011 adder_done_tag, shift_done_tag  in  [0:3]  {port, tag} of completion.
REQ-012 portN_invalid_op (N=1..4)  out  1  registered one-cycle invalid-command pulse.
REQ-013 portN_invalid_tag (N=1..4)  out  [0:1]  tag of the invalid command.
REQ-014 sb_err  out  1  sticky: completion received for a non-outstanding {port,tag}.

Function
REQ-015 cmd 1 (add), 2 (sub) SHALL be adder class; 5 (shl), 6 (shr) shifter class; all other nonzero values invalid.
REQ-016 16-bit scoreboard, one bit per {port,tag}; valid request eligible only if its scoreboard bit (registered value) is clear; otherwise it stalls with no ack.
REQ-017 Per cycle: at most one adder grant and one shifter grant; separate round-robin pointers per unit.
REQ-018 Round-robin: search starts at pointer port, ascending with wrap 4->1; after a grant the pointer moves to granted port+1 (4 wraps to 1); no grant leaves it unchanged.
REQ-019 Grant: reqN_ack=1 same cycle; next cycle prio_*_vld=1 with cmd/tag; scoreboard bit set at same edge. Dispatch latency = 1 cycle.
REQ-020 No grant in a cycle: prio_*_vld=0 next cycle; cmd/tag outputs 0.
REQ-021 Invalid commands: accepted every cycle, all ports in parallel, no scoreboard check or set; ack same cycle; portN_invalid_op=1 with tag next cycle for exactly one cycle.
REQ-022 *_done clears scoreboard bit at the edge; if the bit is already clear, no state change, sb_err set.
REQ-023 adder_done and shift_done in the same cycle: both processed; identical tags -> bit cleared once, sb_err set.
REQ-024 Cleared bit SHALL NOT make its request eligible before the following cycle (registered scoreboard).
REQ-025 sb_err clears only on reset.

Reset
REQ-026 reset=1 at an edge: scoreboard 0, both pointers port 1, sb_err 0, all registered outputs 0.
REQ-027 While reset=1: reqN_ack=0, no grants; *_done ignored (no sb_err).
REQ-028 Reset mid-operation discards all outstanding state; completions after reset release that hit clear bits set sb_err.

Structure
REQ-029 calc2_pkg SHALL hold command encodings (NOP, ADD, SUB, SHL, SHR), NUM_PORTS=4, TAG_W=2, unit-class enum.
REQ-030 One sub-module calc2_rr_pick (4-way request vector + pointer -> one-hot grant + next pointer), instantiated twice.

Verification
REQ-031 Ports 1..4 all issue ADD, distinct tags, done returned each cycle -> adder grants in order 1,2,3,4,1; one ack per cycle.
REQ-032 Port 1 ADD tag 0 and port 2 SHL tag 1 same cycle -> both acked; next cycle prio_adder_tag=0x0, prio_shift_tag=0x5, both vld.
REQ-033 Port 3 ADD tag 2 outstanding, second ADD tag 2 -> no ack until adder_done_tag=0xA; acked the cycle after done, not the done cycle.
REQ-034 Port 4 cmd 0xF tag 3 -> ack same cycle; port4_invalid_op=1, port4_invalid_tag=3 next cycle only; no dispatch; scoreboard unchanged.
REQ-035 shift_done_tag=0x7 with nothing outstanding -> sb_err=1, held until reset.
REQ-036 Reset with 3 tags outstanding -> all outputs 0 next cycle; previously outstanding tags immediately re-grantable after reset deasserts.
